// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding, BCD limits and clamp helper for timer_ctrl
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SEC_T_MAX = 5;
  localparam int ONES_MAX  = 9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] v, input logic [3:0] m);
    return (v > m) ? m : v;
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// rtl/bcd_digit_dn.sv - one decrementing BCD digit with clamped load and borrow chain
module bcd_digit_dn
  import timer_pkg::*;
#(
  parameter int MAX = ONES_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       borrow_in,
  output logic       borrow_out,
  output logic [3:0] q
);

  localparam logic [3:0] MAXV = 4'(MAX);

  // Borrow ripples combinationally so the whole MM:SS chain updates on one edge.
  assign borrow_out = borrow_in && (q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (load) begin
      q <= bcd_clamp(din, MAXV);
    end else if (borrow_in) begin
      q <= (q == 4'd0) ? MAXV : q - 4'd1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - MM:SS countdown timer: prescaler, BCD borrow chain and run/pause/done FSM
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic [2:0] set_min_t,
  input  logic [3:0] set_min_o,
  input  logic [2:0] set_sec_t,
  input  logic [3:0] set_sec_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load_ok, wrap, tick, last, nonzero;
  logic             b_so, b_st, b_mo, unused_borrow;

  assign nonzero = |{min_t, min_o, sec_t, sec_o};
  assign load_ok = load && !clear && (state != ST_RUN);
  assign wrap    = (state == ST_RUN) && (cnt == CNT_W'(TICK_DIV - 1));
  assign tick    = wrap && !clear;
  // The tick that takes 00:01 to 00:00 ends the count on the same edge.
  assign last    = tick && (min_t == 4'd0) && (min_o == 4'd0) &&
                   (sec_t == 4'd0) && (sec_o == 4'd1);

  always_comb begin
    state_nxt = state;
    if (clear || load_ok) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start && !pause && nonzero) state_nxt = ST_RUN;
        ST_RUN:   if (last) state_nxt = ST_DONE;
                  else if (pause) state_nxt = ST_PAUSE;
        ST_PAUSE: if (start && !pause) state_nxt = ST_RUN;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      alarm   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      alarm   <= (state_nxt == ST_DONE);
      done    <= (state_nxt == ST_DONE) && (state != ST_DONE);
    end
  end

  // Held outside RUN so a resume keeps the partial second; wrap also zeroes it on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || load_ok) begin
      cnt <= '0;
    end else if (state == ST_RUN) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  bcd_digit_dn #(.MAX(ONES_MAX)) u_sec_o (
    .clk(clk), .rst_n(rst_n), .clr(clear), .load(load_ok), .din(set_sec_o),
    .borrow_in(tick), .borrow_out(b_so), .q(sec_o)
  );

  bcd_digit_dn #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .clr(clear), .load(load_ok), .din({1'b0, set_sec_t}),
    .borrow_in(b_so), .borrow_out(b_st), .q(sec_t)
  );

  bcd_digit_dn #(.MAX(ONES_MAX)) u_min_o (
    .clk(clk), .rst_n(rst_n), .clr(clear), .load(load_ok), .din(set_min_o),
    .borrow_in(b_st), .borrow_out(b_mo), .q(min_o)
  );

  bcd_digit_dn #(.MAX(SEC_T_MAX)) u_min_t (
    .clk(clk), .rst_n(rst_n), .clr(clear), .load(load_ok), .din({1'b0, set_min_t}),
    .borrow_in(b_mo), .borrow_out(unused_borrow), .q(min_t)
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - table-driven and sequence checks for timer_ctrl with TICK_DIV=4
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0;
  logic [2:0] set_min_t = '0, set_sec_t = '0;
  logic [3:0] set_min_o = '0, set_sec_o = '0;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       running, alarm, done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       s, p, c, l;
    logic [2:0] smt;
    logic [3:0] smo;
    logic [2:0] sst;
    logic [3:0] sso;
    logic [15:0] ed;
    logic       er, ea, edn;
  } vec_t;

  vec_t vecs[$];

  timer_ctrl #(.TICK_DIV(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear), .load(load),
    .set_min_t(set_min_t), .set_min_o(set_min_o), .set_sec_t(set_sec_t), .set_sec_o(set_sec_o),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .running(running), .alarm(alarm), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic s, p, c, l, input logic [2:0] smt, input logic [3:0] smo,
                     input logic [2:0] sst, input logic [3:0] sso, input logic [15:0] ed,
                     input logic er, ea, edn);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.l = l;
    v.smt = smt; v.smo = smo; v.sst = sst; v.sso = sso;
    v.ed = ed; v.er = er; v.ea = ea; v.edn = edn;
    vecs.push_back(v);
  endtask

  task automatic step(input logic s, p, c, l, input logic [2:0] smt, input logic [3:0] smo,
                      input logic [2:0] sst, input logic [3:0] sso);
    @(negedge clk);
    start = s; pause = p; clear = c; load = l;
    set_min_t = smt; set_min_o = smo; set_sec_t = sst; set_sec_o = sso;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input int id, input logic [15:0] ed, input logic er, ea, edn);
    logic [18:0] act, exp_v;
    act   = {min_t, min_o, sec_t, sec_o, running, alarm, done};
    exp_v = {ed, er, ea, edn};
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL chk%0d: got digits=%h run/alarm/done=%b required digits=%h run/alarm/done=%b",
               id, act[18:3], act[2:0], exp_v[18:3], exp_v[2:0]);
    end
  endtask

  task automatic check_int(input int id, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL chk%0d: got %0d required %0d", id, got, req);
    end
  endtask

  initial begin
    int n;
    int bad_bcd;
    int bad_hold;

    // one-cycle vectors: s p c l | smt smo sst sso | digits run alarm done
    add(0,0,0,0, 0,0,0,0,      16'h0000, 0,0,0);
    add(1,0,0,0, 0,0,0,0,      16'h0000, 0,0,0);
    add(0,0,0,1, 1,2,3,4,      16'h1234, 0,0,0);
    add(0,0,0,1, 7,0,0,4'hC,   16'h5009, 0,0,0);
    add(0,0,0,1, 7,4'hF,6,4'hA,16'h5959, 0,0,0);
    add(0,0,1,1, 1,2,3,4,      16'h0000, 0,0,0);
    add(0,0,0,1, 0,0,0,3,      16'h0003, 0,0,0);
    add(1,1,0,0, 0,0,0,0,      16'h0003, 0,0,0);
    add(1,0,0,0, 0,0,0,0,      16'h0003, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0003, 1,0,0);
    add(0,0,0,1, 0,5,5,5,      16'h0003, 1,0,0);
    add(1,1,0,0, 0,0,0,0,      16'h0003, 0,0,0);
    add(1,1,0,0, 0,0,0,0,      16'h0003, 0,0,0);
    add(1,0,0,0, 0,0,0,0,      16'h0003, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0002, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0002, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0002, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0002, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0001, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0001, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0001, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0001, 1,0,0);
    add(0,0,0,0, 0,0,0,0,      16'h0000, 0,1,1);
    add(0,0,0,0, 0,0,0,0,      16'h0000, 0,1,0);
    add(1,0,0,0, 0,0,0,0,      16'h0000, 0,1,0);
    add(0,0,0,1, 0,0,0,2,      16'h0002, 0,0,0);
    add(1,0,0,0, 0,0,0,0,      16'h0002, 1,0,0);
    add(0,0,1,0, 0,0,0,0,      16'h0000, 0,0,0);

    #12;
    check(90, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].l,
           vecs[i].smt, vecs[i].smo, vecs[i].sst, vecs[i].sso);
      check(i, vecs[i].ed, vecs[i].er, vecs[i].ea, vecs[i].edn);
    end

    // full 01:00 countdown
    step(0,0,0,1, 0,1,0,0);
    step(1,0,0,0, 0,0,0,0);
    check(100, 16'h0100, 1, 0, 0);
    bad_bcd = 0;
    n = 0;
    while (n < 300) begin
      idle();
      n++;
      if (sec_o > 4'd9 || sec_t > 4'd5 || min_o > 4'd9 || min_t > 4'd5) bad_bcd++;
      if (n == 4) check(101, 16'h0059, 1, 0, 0);
      if (done) break;
    end
    check_int(102, n, 240);
    check(103, 16'h0000, 0, 1, 1);
    check_int(104, bad_bcd, 0);
    idle();
    check(105, 16'h0000, 0, 1, 0);
    step(0,0,1,0, 0,0,0,0);
    check(106, 16'h0000, 0, 0, 0);
    step(1,0,0,0, 0,0,0,0);
    check(107, 16'h0000, 0, 0, 0);

    // borrow chain
    step(0,0,0,1, 1,0,0,0);
    step(1,0,0,0, 0,0,0,0);
    repeat (4) idle();
    check(110, 16'h0959, 1, 0, 0);
    step(0,0,1,0, 0,0,0,0);
    step(0,0,0,1, 0,0,1,0);
    step(1,0,0,0, 0,0,0,0);
    repeat (4) idle();
    check(111, 16'h0009, 1, 0, 0);
    step(0,0,1,0, 0,0,0,0);

    // pause keeps the partial second
    step(0,0,0,1, 0,0,0,5);
    step(1,0,0,0, 0,0,0,0);
    idle();
    step(0,1,0,0, 0,0,0,0);
    check(120, 16'h0005, 0, 0, 0);
    bad_hold = 0;
    repeat (20) begin
      idle();
      if ({min_t, min_o, sec_t, sec_o} !== 16'h0005 || running !== 1'b0) bad_hold++;
    end
    check_int(121, bad_hold, 0);
    step(1,0,0,0, 0,0,0,0);
    check(122, 16'h0005, 1, 0, 0);
    idle();
    check(123, 16'h0005, 1, 0, 0);
    idle();
    check(124, 16'h0004, 1, 0, 0);
    step(0,0,1,0, 0,0,0,0);

    // asynchronous reset mid-count
    step(0,0,0,1, 0,0,0,7);
    step(1,0,0,0, 0,0,0,0);
    repeat (6) idle();
    check(130, 16'h0006, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check(131, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check(132, 16'h0000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
